// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the memory port arbiter and its clients.
//   rd_tag_e   : owner of the read whose data appears on mem_rdata next cycle
//   VEC_RESET  : vec_sel value selecting the reset vector M[0]
//   VEC_INTR   : vec_sel value selecting the interrupt vector M[1]
package cpu_pkg;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VEC  = 2'd1,
        TAG_DM   = 2'd2,
        TAG_IF   = 2'd3
    } rd_tag_e;

    localparam logic VEC_RESET = 1'b0;
    localparam logic VEC_INTR  = 1'b1;

    // A grant produces a read return unless it is a data-stage write.
    function automatic rd_tag_e read_tag(input rd_tag_e owner, input logic dm_we);
        return (owner == TAG_DM && dm_we) ? TAG_NONE : owner;
    endfunction

endpackage

// File: rtl/starve_counter.sv
// starve_counter: saturating count of consecutive cycles in which fetch asked
// for the memory and was refused.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   inc        : fetch requested and was not granted this cycle
//   clr        : fetch granted or not requesting (wins over inc)
//   at_max     : count has reached STARVE_MAX
module starve_counter
#(
    parameter int CW         = 3,
    parameter int STARVE_MAX = 4
)
(
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    logic [CW-1:0] cnt;

    assign at_max = (cnt == CW'(STARVE_MAX));

    always_ff @(posedge clk) begin
        if (reset || clr)
            cnt <= '0;
        else if (inc && !at_max)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-port synchronous memory between the
// vector fetch, the data stage and instruction fetch.
//   clk, reset                 : rising-edge clock, synchronous active-high reset
//   vec_req/vec_sel            : vector read of M[vec_sel]; vec_gnt, vec_rvalid back
//   dm_req/we/lock/addr/wdata  : data-stage access; dm_gnt, dm_rvalid back
//   if_req/if_addr             : instruction fetch; if_gnt, if_rvalid, stall_if back
//   mem_en/we/addr/wdata       : memory command, combinational in the grant cycle
//   mem_rdata                  : memory read data, valid the cycle after the address
// One grant per cycle. Priority is vec > dm > if, except that a starved fetch
// overtakes dm, and a locked dm (multi-byte push/pop) overtakes everything.
// Read data is not re-registered; each client qualifies mem_rdata with its rvalid.
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int STARVE_MAX = 4,
    parameter int CW         = 3
)
(
    input  logic          clk,
    input  logic          reset,
    input  logic          vec_req,
    input  logic          vec_sel,
    output logic          vec_gnt,
    output logic          vec_rvalid,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic          dm_lock,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic          stall_if,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    rd_tag_e win;
    rd_tag_e rd_tag;
    logic    lock_q;
    logic    fetch_starved;

    // Winner of this cycle. lock_q only counts while dm still requests.
    always_comb begin
        win = TAG_NONE;
        if (!reset) begin
            if (lock_q && dm_req)
                win = TAG_DM;
            else if (vec_req)
                win = TAG_VEC;
            else if (if_req && fetch_starved)
                win = TAG_IF;
            else if (dm_req)
                win = TAG_DM;
            else if (if_req)
                win = TAG_IF;
        end
    end

    assign vec_gnt  = (win == TAG_VEC);
    assign dm_gnt   = (win == TAG_DM);
    assign if_gnt   = (win == TAG_IF);
    assign stall_if = if_req & ~if_gnt;
    assign mem_en   = vec_gnt | dm_gnt | if_gnt;
    assign mem_we   = dm_gnt & dm_we;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        case (win)
            TAG_VEC: mem_addr = {{(AW-1){1'b0}}, vec_sel};
            TAG_DM: begin
                mem_addr  = dm_addr;
                mem_wdata = dm_wdata;
            end
            TAG_IF:  mem_addr = if_addr;
            default: ;
        endcase
    end

    starve_counter #(
        .CW         (CW),
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk    (clk),
        .reset  (reset),
        .inc    (if_req & ~if_gnt),
        .clr    (if_gnt | ~if_req),
        .at_max (fetch_starved)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_tag <= TAG_NONE;
            lock_q <= 1'b0;
        end else begin
            rd_tag <= read_tag(win, dm_we);
            lock_q <= dm_lock & dm_gnt;
        end
    end

    // Gated by reset so a read granted just before reset rises returns
    // nothing: the tag loaded on that edge is already being dropped.
    assign vec_rvalid = ~reset & (rd_tag == TAG_VEC);
    assign dm_rvalid  = ~reset & (rd_tag == TAG_DM);
    assign if_rvalid  = ~reset & (rd_tag == TAG_IF);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int STARVE_MAX = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          vec_req, vec_sel, vec_gnt, vec_rvalid;
    logic          dm_req, dm_we, dm_lock, dm_gnt, dm_rvalid;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          if_req, if_gnt, if_rvalid, stall_if;
    logic [AW-1:0] if_addr;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX), .CW(CW)) dut (
        .clk(clk), .reset(reset),
        .vec_req(vec_req), .vec_sel(vec_sel), .vec_gnt(vec_gnt), .vec_rvalid(vec_rvalid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_lock(dm_lock), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .stall_if(stall_if),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Memory environment: unwritten locations read as address + 0x10.
    logic [DW-1:0] mem [0:255];
    bit            mem_wv [0:255];
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mem[mem_addr]    <= mem_wdata;
            mem_wv[mem_addr] <= 1'b1;
        end
        if (mem_en && !mem_we)
            mem_rdata <= mem_wv[mem_addr] ? mem[mem_addr] : DW'(mem_addr + 8'h10);
    end

    // Reference model state (requester ids: 0 none, 1 vec, 2 dm, 3 if).
    logic [DW-1:0] m_mem [0:255];
    bit            m_wv [0:255];
    int            m_starve = 0;
    bit            m_lock = 0;
    int            m_tag = 0;
    logic [DW-1:0] m_data = '0;
    int            m_last_w = 0;

    // Observed values of the last cycle, for scenario-level checks.
    logic obs_vec_gnt, obs_dm_gnt, obs_if_gnt, obs_stall, obs_en, obs_we;
    logic obs_vec_rv, obs_dm_rv, obs_if_rv;
    logic [AW-1:0] obs_addr;
    logic [DW-1:0] obs_wdata, obs_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a);
        return m_wv[a] ? m_mem[a] : DW'(a + 8'h10);
    endfunction

    // One clock cycle: predict from the rules, check at negedge, advance model.
    task automatic cyc();
        int w;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        w = 0;
        if (!reset) begin
            if (m_lock && dm_req)                           w = 2;
            else if (vec_req)                               w = 1;
            else if (if_req && m_starve == STARVE_MAX)      w = 3;
            else if (dm_req)                                w = 2;
            else if (if_req)                                w = 3;
        end
        ea = (w == 1) ? AW'(vec_sel) : (w == 2) ? dm_addr : (w == 3) ? if_addr : '0;
        ed = (w == 2) ? dm_wdata : '0;
        @(negedge clk);
        obs_vec_gnt = vec_gnt; obs_dm_gnt = dm_gnt; obs_if_gnt = if_gnt;
        obs_stall = stall_if; obs_en = mem_en; obs_we = mem_we;
        obs_addr = mem_addr; obs_wdata = mem_wdata; obs_rdata = mem_rdata;
        obs_vec_rv = vec_rvalid; obs_dm_rv = dm_rvalid; obs_if_rv = if_rvalid;
        check("vec_gnt", 32'(vec_gnt), 32'(w == 1));
        check("dm_gnt", 32'(dm_gnt), 32'(w == 2));
        check("if_gnt", 32'(if_gnt), 32'(w == 3));
        check("stall_if", 32'(stall_if), 32'(if_req && w != 3));
        check("mem_en", 32'(mem_en), 32'(w != 0));
        check("mem_we", 32'(mem_we), 32'(w == 2 && dm_we));
        check("mem_addr", 32'(mem_addr), 32'(ea));
        check("mem_wdata", 32'(mem_wdata), 32'(ed));
        check("vec_rvalid", 32'(vec_rvalid), 32'(!reset && m_tag == 1));
        check("dm_rvalid", 32'(dm_rvalid), 32'(!reset && m_tag == 2));
        check("if_rvalid", 32'(if_rvalid), 32'(!reset && m_tag == 3));
        if (!reset && m_tag != 0)
            check("rdata", 32'(mem_rdata), 32'(m_data));
        @(posedge clk);
        m_last_w = w;
        if (reset) begin
            m_tag = 0; m_starve = 0; m_lock = 0;
        end else begin
            m_tag  = (w == 2 && dm_we) ? 0 : w;
            m_data = m_rd(ea);
            if (w == 2 && dm_we) begin
                m_mem[ea] = ed;
                m_wv[ea]  = 1'b1;
            end
            m_lock = (w == 2) && dm_lock;
            if (if_req && w != 3)
                m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
            else
                m_starve = 0;
        end
        #1;
    endtask

    task automatic idle();
        vec_req = 0; vec_sel = 0;
        dm_req = 0; dm_we = 0; dm_lock = 0; dm_addr = '0; dm_wdata = '0;
        if_req = 0; if_addr = '0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        @(posedge clk); #1;

        // 1: reset with every request high, then reset-vector read.
        vec_req = 1; dm_req = 1; if_req = 1;
        repeat (2) begin
            cyc();
            check("t1_rst_gnts", 32'({obs_vec_gnt, obs_dm_gnt, obs_if_gnt}), 32'(0));
            check("t1_rst_en", 32'(obs_en), 32'(0));
            check("t1_rst_stall", 32'(obs_stall), 32'(1));
        end
        reset = 0; idle(); vec_req = 1; vec_sel = 0;
        cyc();
        check("t1_vec_gnt", 32'(obs_vec_gnt), 32'(1));
        check("t1_vec_addr", 32'(obs_addr), 32'(0));
        idle();
        cyc();
        check("t1_vec_rvalid", 32'(obs_vec_rv), 32'(1));
        check("t1_vec_data", 32'(obs_rdata), 32'h10);

        // 2: fetch starvation and promotion.
        if_req = 1; if_addr = 8'h80; dm_req = 1; dm_we = 0; dm_addr = 8'h40;
        for (int c = 0; c < 6; c++) begin
            cyc();
            if (c < 4) begin
                check("t2_dm_gnt", 32'(obs_dm_gnt), 32'(1));
                check("t2_stall", 32'(obs_stall), 32'(1));
            end else if (c == 4) begin
                check("t2_if_promoted", 32'(obs_if_gnt), 32'(1));
            end else begin
                check("t2_dm_after", 32'(obs_dm_gnt), 32'(1));
            end
        end
        idle(); cyc();

        // 3: data write.
        dm_req = 1; dm_we = 1; dm_addr = 8'h20; dm_wdata = 8'hA5;
        cyc();
        check("t3_mem_we", 32'(obs_we), 32'(1));
        check("t3_wdata", 32'(obs_wdata), 32'hA5);
        idle(); cyc();
        check("t3_no_rvalid", 32'(obs_dm_rv), 32'(0));
        dm_req = 1; dm_addr = 8'h20; cyc();
        idle(); cyc();
        check("t3_readback", 32'(obs_rdata), 32'hA5);

        // 4: lock holds the port against a vector request.
        dm_req = 1; dm_lock = 1; dm_addr = 8'h30;
        cyc();
        check("t4_dm_c0", 32'(obs_dm_gnt), 32'(1));
        vec_req = 1; vec_sel = 1; dm_lock = 0; dm_addr = 8'h31;
        cyc();
        check("t4_dm_c1", 32'(obs_dm_gnt), 32'(1));
        check("t4_vec_c1", 32'(obs_vec_gnt), 32'(0));
        dm_req = 0;
        cyc();
        check("t4_vec_c2", 32'(obs_vec_gnt), 32'(1));
        idle(); cyc();

        // 5: back-to-back reads IF, DM, VEC.
        if_req = 1; if_addr = 8'h05; cyc();
        idle(); dm_req = 1; dm_addr = 8'h06; cyc();
        check("t5_if_rv", 32'({obs_vec_rv, obs_dm_rv, obs_if_rv}), 32'(3'b001));
        idle(); vec_req = 1; vec_sel = 1; cyc();
        check("t5_dm_rv", 32'({obs_vec_rv, obs_dm_rv, obs_if_rv}), 32'(3'b010));
        idle(); cyc();
        check("t5_vec_rv", 32'({obs_vec_rv, obs_dm_rv, obs_if_rv}), 32'(3'b100));
        cyc();
        check("t5_none_rv", 32'({obs_vec_rv, obs_dm_rv, obs_if_rv}), 32'(3'b000));

        // 6: reset right after a fetch read grant drops the return.
        if_req = 1; if_addr = 8'h07; cyc();
        check("t6_if_gnt", 32'(obs_if_gnt), 32'(1));
        idle(); reset = 1; cyc();
        check("t6_if_rv_rst", 32'(obs_if_rv), 32'(0));
        reset = 0; cyc();
        check("t6_if_rv_after", 32'(obs_if_rv), 32'(0));

        // Random traffic; requesters hold their request until granted.
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 63) == 0);
            if (!vec_req || m_last_w == 1) begin
                vec_req = ($urandom_range(0, 3) == 0);
                vec_sel = 1'($urandom);
            end
            if (!dm_req || m_last_w == 2) begin
                dm_req   = ($urandom_range(0, 1) == 0);
                dm_we    = ($urandom_range(0, 2) == 0);
                dm_lock  = ($urandom_range(0, 3) == 0);
                dm_addr  = AW'($urandom);
                dm_wdata = DW'($urandom);
            end
            if (!if_req || m_last_w == 3) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = AW'($urandom);
            end
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
